// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full flag set and registered handshake flags.
//   Params : FIFO_WIDTH (word bits), FIFO_DEPTH (entries, >= 4, any value)
//   Inputs : clk, rst (async active-high), data_in, wr_en, rd_en
//   Outputs: data_out (registered read data), wr_ack/overflow/underflow (registered,
//            describe the previous-cycle access), full/empty/almostfull/almostempty
//            (combinational from the occupancy count)
//   Macro  : SYNC_FIFO_SVA_EN compiles in assertions and covers
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_M1 = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] LAST_P = AW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    assign full        = count_q == DEPTH_C;
    assign empty       = count_q == '0;
    assign almostfull  = count_q == DEPTH_M1;
    assign almostempty = count_q == (AW+1)'(1);
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ok ? (wr_ptr_q == LAST_P ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = rd_ok ? (rd_ptr_q == LAST_P ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d     = (wr_ok && !rd_ok) ? count_q + 1'b1 :
                      (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
        data_out_d  = rd_ok ? mem[rd_ptr_q] : data_out_q;
        wr_ack_d    = wr_ok;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; stale contents are never readable.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= data_in;
    end

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef SYNC_FIFO_SVA_EN
    a_count_max:  assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
    a_full_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_wr_ack:     assert property (@(posedge clk) disable iff (rst) wr_ok |=> wr_ack);
    a_overflow:   assert property (@(posedge clk) disable iff (rst) wr_en && full && !rd_en |=> overflow && full);
    a_underflow:  assert property (@(posedge clk) disable iff (rst) rd_en && empty && !wr_en |=> underflow && empty);
    a_wr_wrap:    assert property (@(posedge clk) disable iff (rst) wr_ok && wr_ptr_q == LAST_P |=> wr_ptr_q == '0);
    a_rd_wrap:    assert property (@(posedge clk) disable iff (rst) rd_ok && rd_ptr_q == LAST_P |=> rd_ptr_q == '0);
    c_full:       cover property (@(posedge clk) disable iff (rst) full);
    c_empty:      cover property (@(posedge clk) disable iff (rst) empty);
    c_almostfull: cover property (@(posedge clk) disable iff (rst) almostfull);
    c_almostempty: cover property (@(posedge clk) disable iff (rst) almostempty);
    c_overflow:   cover property (@(posedge clk) disable iff (rst) overflow);
    c_underflow:  cover property (@(posedge clk) disable iff (rst) underflow);
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH 8, WIDTH 16).
module tb_sync_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [6:0]  flags;
    int          checks = 0;
    int          errors = 0;

    sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    // {wr_ack, overflow, underflow, full, empty, almostfull, almostempty}
    assign flags = {wr_ack, overflow, underflow, full, empty, almostfull, almostempty};

    task automatic cyc(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 7'b0000100); end
        checks++;
        if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want %h", data_out, 16'h0000); end
        rst = 1'b0;
    endtask

    task automatic test_fill_drain;
        logic [6:0] e;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            e = {1'b1, 1'b0, 1'b0, i == 8, 1'b0, i == 7, i == 1};
            checks++;
            if (flags !== e) begin errors++; $display("FAIL fill_flags[%0d]: got %b want %b", i, flags, e); end
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            e = {1'b0, 1'b0, 1'b0, 1'b0, i == 8, i == 1, i == 7};
            checks++;
            if (data_out !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, 16'(i)); end
            checks++;
            if (flags !== e) begin errors++; $display("FAIL drain_flags[%0d]: got %b want %b", i, flags, e); end
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
        cyc(1'b1, 1'b0, 16'hBEEF);
        checks++;
        if (flags !== 7'b0101000) begin errors++; $display("FAIL ovf_flags: got %b want %b", flags, 7'b0101000); end
        cyc(1'b0, 1'b0, 16'h0);
        checks++;
        if (flags !== 7'b0001000) begin errors++; $display("FAIL ovf_pulse_end: got %b want %b", flags, 7'b0001000); end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            checks++;
            if (data_out !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, data_out, 16'h0100 + 16'(i)); end
        end
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL ovf_empty: got %b want %b", flags, 7'b0000100); end
    endtask

    task automatic test_underflow;
        cyc(1'b0, 1'b1, 16'h0);
        checks++;
        if (flags !== 7'b0010100) begin errors++; $display("FAIL udf_flags: got %b want %b", flags, 7'b0010100); end
        checks++;
        if (data_out !== 16'h0108) begin errors++; $display("FAIL udf_hold: got %h want %h", data_out, 16'h0108); end
        cyc(1'b0, 1'b0, 16'h0);
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL udf_pulse_end: got %b want %b", flags, 7'b0000100); end
    endtask

    task automatic test_simultaneous;
        cyc(1'b1, 1'b1, 16'h00AA);
        checks++;
        if (flags !== 7'b1010001) begin errors++; $display("FAIL sim_empty_flags: got %b want %b", flags, 7'b1010001); end
        checks++;
        if (data_out !== 16'h0108) begin errors++; $display("FAIL sim_empty_hold: got %h want %h", data_out, 16'h0108); end
        cyc(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== 16'h00AA) begin errors++; $display("FAIL sim_empty_read: got %h want %h", data_out, 16'h00AA); end
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
        cyc(1'b1, 1'b1, 16'hCAFE);
        checks++;
        if (flags !== 7'b0100010) begin errors++; $display("FAIL sim_full_flags: got %b want %b", flags, 7'b0100010); end
        checks++;
        if (data_out !== 16'h0201) begin errors++; $display("FAIL sim_full_data: got %h want %h", data_out, 16'h0201); end
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            checks++;
            if (data_out !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL sim_full_drain[%0d]: got %h want %h", i, data_out, 16'h0200 + 16'(i)); end
        end
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL sim_full_empty: got %b want %b", flags, 7'b0000100); end
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 16'h0300 + 16'(i));
        cyc(1'b1, 1'b1, 16'h0305);
        checks++;
        if (flags !== 7'b1000000) begin errors++; $display("FAIL sim_mid_flags: got %b want %b", flags, 7'b1000000); end
        checks++;
        if (data_out !== 16'h0301) begin errors++; $display("FAIL sim_mid_data: got %h want %h", data_out, 16'h0301); end
        for (int i = 2; i <= 5; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            checks++;
            if (data_out !== 16'h0300 + 16'(i)) begin errors++; $display("FAIL sim_mid_drain[%0d]: got %h want %h", i, data_out, 16'h0300 + 16'(i)); end
        end
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL sim_mid_empty: got %b want %b", flags, 7'b0000100); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b0, 16'h0400 + 16'(k));
            checks++;
            if (flags !== 7'b1000001) begin errors++; $display("FAIL wrap_wr_flags[%0d]: got %b want %b", k, flags, 7'b1000001); end
            cyc(1'b0, 1'b1, 16'h0);
            checks++;
            if (data_out !== 16'h0400 + 16'(k)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, data_out, 16'h0400 + 16'(k)); end
            checks++;
            if (flags !== 7'b0000100) begin errors++; $display("FAIL wrap_rd_flags[%0d]: got %b want %b", k, flags, 7'b0000100); end
        end
    endtask

    task automatic test_reset_midstream;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 16'h0500 + 16'(i));
        cyc(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== 16'h0501) begin errors++; $display("FAIL mid_pre_data: got %h want %h", data_out, 16'h0501); end
        wr_en = 1'b1;
        data_in = 16'hDEAD;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL mid_rst_flags: got %b want %b", flags, 7'b0000100); end
        checks++;
        if (data_out !== 16'h0000) begin errors++; $display("FAIL mid_rst_data: got %h want %h", data_out, 16'h0000); end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        checks++;
        if (flags !== 7'b0000100) begin errors++; $display("FAIL mid_rst_hold: got %b want %b", flags, 7'b0000100); end
        rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h0600);
        checks++;
        if (flags !== 7'b1000001) begin errors++; $display("FAIL mid_post_wr: got %b want %b", flags, 7'b1000001); end
        cyc(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== 16'h0600) begin errors++; $display("FAIL mid_post_rd: got %h want %h", data_out, 16'h0600); end
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_overflow;
        test_underflow;
        test_simultaneous;
        test_wrap;
        test_reset_midstream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
